// File: rtl/matrix_pkg.sv
// Shared types for the matrix read sequencer: read-buffer select codes,
// sequencer states and the BRAM read latency.
package matrix_pkg;

    typedef enum logic [1:0] {
        SEL_BUF0 = 2'b00,
        SEL_BUF1 = 2'b01,
        SEL_RAM  = 2'b10
    } dp_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } rd_state_e;

    localparam int RAM_RD_LAT = 2;

endpackage

// File: rtl/matrix_addr_walk.sv
// Address generator for an R x C row-major matrix, walked either row-major
// or column-major; flags the final element of the walk.
module matrix_addr_walk #(
    parameter int ADDR_MSB = 11,
    parameter int DIM_W    = 7
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic                load,
    input  logic                advance,
    input  logic [ADDR_MSB:0]   cfg_base,
    input  logic [DIM_W-1:0]    cfg_rows,
    input  logic [DIM_W-1:0]    cfg_cols,
    input  logic                cfg_col_major,
    output logic [ADDR_MSB:0]   addr,
    output logic                last
);

    typedef logic [ADDR_MSB:0] addr_t;
    typedef logic [DIM_W-1:0]  dim_t;

    addr_t line_ptr;
    dim_t  row_idx;
    dim_t  col_idx;
    dim_t  rows_q;
    dim_t  cols_q;
    logic  col_major_q;
    logic  row_end;
    logic  col_end;

    assign row_end = (row_idx + dim_t'(1)) == rows_q;
    assign col_end = (col_idx + dim_t'(1)) == cols_q;
    assign last    = row_end && col_end;

    always_ff @(posedge clka) begin
        if (rsta) begin
            addr        <= '0;
            line_ptr    <= '0;
            row_idx     <= '0;
            col_idx     <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            col_major_q <= 1'b0;
        end else if (load) begin
            addr        <= cfg_base;
            line_ptr    <= cfg_base;
            row_idx     <= '0;
            col_idx     <= '0;
            rows_q      <= cfg_rows;
            cols_q      <= cfg_cols;
            col_major_q <= cfg_col_major;
        end else if (advance) begin
            if (col_major_q) begin
                // Column walk: stride by C down a column, then restart at the next column head.
                if (row_end) begin
                    row_idx  <= '0;
                    col_idx  <= col_idx + dim_t'(1);
                    line_ptr <= line_ptr + addr_t'(1);
                    addr     <= line_ptr + addr_t'(1);
                end else begin
                    row_idx <= row_idx + dim_t'(1);
                    addr    <= addr + addr_t'(cols_q);
                end
            end else begin
                addr <= addr + addr_t'(1);
                if (col_end) begin
                    col_idx <= '0;
                    row_idx <= row_idx + dim_t'(1);
                end else begin
                    col_idx <= col_idx + dim_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matrix_rd_seq.sv
// Read sequencer feeding matrix_dp: issues one BRAM read per cycle under a
// two-element credit limit and streams the results out as valid/ready.
//
// state | meaning
// IDLE  | waiting for start; zero-sized walks complete here
// RUN   | issuing reads, one address per credit
// DRAIN | all addresses issued, waiting for the last element to be popped
module matrix_rd_seq
    import matrix_pkg::*;
#(
    parameter int ADDR_MSB = 11,
    parameter int DIM_W    = 7
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic                start,
    input  logic [ADDR_MSB:0]   cfg_base,
    input  logic [DIM_W-1:0]    cfg_rows,
    input  logic [DIM_W-1:0]    cfg_cols,
    input  logic                cfg_col_major,
    output logic                busy,
    output logic                done,
    output logic [ADDR_MSB:0]   dp_addra,
    output logic                dp_shift,
    output logic [1:0]          dp_out_sel,
    input  logic [31:0]         dp_douta,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [31:0]         m_data,
    output logic                m_last
);

    typedef logic [2*DIM_W-1:0] rem_t;

    rd_state_e             state;
    rd_state_e             state_nxt;
    logic [RAM_RD_LAT-1:0] iss_pipe;
    logic [1:0]            outstanding;
    logic                  v0;
    logic                  v1;
    rem_t                  remaining;
    logic                  zero_done;
    logic                  size_zero;
    logic                  start_ok;
    logic                  issue;
    logic                  arr;
    logic                  pop;
    logic                  walk_last;
    dp_sel_e               head;

    assign size_zero = (cfg_rows == '0) || (cfg_cols == '0);
    assign start_ok  = (state == IDLE) && start;
    assign arr       = iss_pipe[RAM_RD_LAT-1];
    assign m_valid   = v0 || v1 || arr;
    assign pop       = m_valid && m_ready;
    // A pop in the same cycle frees a credit, so issue may follow m_ready combinationally.
    assign issue     = (state == RUN) && ((outstanding != 2'd2) || pop);
    assign dp_shift  = arr && !((head == SEL_RAM) && pop);
    assign dp_out_sel = head;
    assign m_data    = dp_douta;
    assign m_last    = m_valid && (remaining == rem_t'(1));

    always_comb begin
        head = SEL_RAM;
        if (v0)
            head = SEL_BUF0;
        else if (v1)
            head = SEL_BUF1;
    end

    matrix_addr_walk #(
        .ADDR_MSB (ADDR_MSB),
        .DIM_W    (DIM_W)
    ) u_walk (
        .clka          (clka),
        .rsta          (rsta),
        .load          (start_ok && !size_zero),
        .advance       (issue),
        .cfg_base      (cfg_base),
        .cfg_rows      (cfg_rows),
        .cfg_cols      (cfg_cols),
        .cfg_col_major (cfg_col_major),
        .addr          (dp_addra),
        .last          (walk_last)
    );

    always_ff @(posedge clka) begin
        if (rsta)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !size_zero) state_nxt = RUN;
            RUN:     if (issue && walk_last) state_nxt = DRAIN;
            DRAIN:   if (outstanding == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = zero_done;
        case (state)
            RUN:   busy = 1'b1;
            DRAIN: begin
                busy = 1'b1;
                if (outstanding == 2'd0)
                    done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            iss_pipe    <= '0;
            outstanding <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            remaining   <= '0;
            zero_done   <= 1'b0;
        end else begin
            iss_pipe    <= {iss_pipe[RAM_RD_LAT-2:0], issue};
            outstanding <= outstanding + 2'(issue) - 2'(pop);
            zero_done   <= start_ok && size_zero;
            if (start_ok)
                remaining <= rem_t'(cfg_rows) * rem_t'(cfg_cols);
            else if (pop)
                remaining <= remaining - rem_t'(1);
            // On shift the arrival lands in buf1 and buf1 moves down to buf0.
            if (dp_shift) begin
                v0 <= v1 && !(pop && (head == SEL_BUF1));
                v1 <= 1'b1;
            end else begin
                v0 <= v0 && !pop;
                v1 <= v1 && !(pop && (head == SEL_BUF1));
            end
        end
    end

    a_buf_state: assert property (@(posedge clka) disable iff (rsta) !(v0 && !v1));
    a_no_overflow: assert property (@(posedge clka) disable iff (rsta) !(arr && v0 && v1));
    a_credit: assert property (@(posedge clka) disable iff (rsta) outstanding <= 2'd2);

endmodule

// File: tb/tb_matrix_rd_seq.sv
// Bench for matrix_rd_seq: behavioural matrix_dp model, expected-element
// queue filled from matrix index arithmetic, monitor popping on each handshake.
module tb_matrix_rd_seq;
    localparam int ADDR_MSB = 11;
    localparam int DIM_W    = 7;
    localparam int AW       = ADDR_MSB + 1;

    logic                clka = 1'b0;
    logic                rsta = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_MSB:0]   cfg_base = '0;
    logic [DIM_W-1:0]    cfg_rows = '0;
    logic [DIM_W-1:0]    cfg_cols = '0;
    logic                cfg_col_major = 1'b0;
    logic                busy;
    logic                done;
    logic [ADDR_MSB:0]   dp_addra;
    logic                dp_shift;
    logic [1:0]          dp_out_sel;
    logic [31:0]         dp_douta;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [31:0]         m_data;
    logic                m_last;

    always #5 clka = ~clka;

    matrix_rd_seq #(.ADDR_MSB(ADDR_MSB), .DIM_W(DIM_W)) dut (
        .clka          (clka),
        .rsta          (rsta),
        .start         (start),
        .cfg_base      (cfg_base),
        .cfg_rows      (cfg_rows),
        .cfg_cols      (cfg_cols),
        .cfg_col_major (cfg_col_major),
        .busy          (busy),
        .done          (done),
        .dp_addra      (dp_addra),
        .dp_shift      (dp_shift),
        .dp_out_sel    (dp_out_sel),
        .dp_douta      (dp_douta),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last)
    );

    // matrix_dp model: 2-cycle BRAM read, two-entry shift buffer, output mux.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] ram_s1, ram_s2, buf0, buf1;

    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i);

    always @(posedge clka) begin
        ram_s1 <= mem[dp_addra];
        ram_s2 <= ram_s1;
        if (dp_shift) begin
            buf0 <= buf1;
            buf1 <= ram_s2;
        end
    end

    always_comb begin
        case (dp_out_sel)
            2'b00:   dp_douta = buf0;
            2'b01:   dp_douta = buf1;
            default: dp_douta = ram_s2;
        endcase
    end

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    int   start_cyc = 0;
    int   first_pop = -1;
    int   last_pop = -1;
    int   pop_cnt = 0;
    bit   done_due = 1'b0;
    bit   zero_start = 1'b0;
    int   rdy_mode = 0;
    int   rdy_idx = 0;
    bit   rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clka) begin
        ncyc++;
        if (rsta) begin
            done_due = 1'b0;
        end else begin
            if (done || done_due)
                check("done", 32'(done), 32'(done_due));
            done_due = zero_start;
            if (start && !busy)
                start_cyc = ncyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_element: got %h expected none", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("m_data", m_data, mon_e.data);
                    check("m_last", 32'(m_last), 32'(mon_e.last));
                    if (mon_e.last) done_due = 1'b1;
                end
                if (first_pop < 0) first_pop = ncyc;
                last_pop = ncyc;
                pop_cnt++;
            end
        end
    end

    initial forever begin
        @(posedge clka);
        #1;
        if (rdy_mode == 0) begin
            m_ready = 1'b1;
        end else begin
            if (rdy_idx < 6) m_ready = rdy_pat[rdy_idx];
            else             m_ready = ($urandom_range(0, 2) != 0);
            rdy_idx++;
        end
    end

    // Element [i][j] lives at base + i*C + j; expected data is its address.
    task automatic push_walk(input int base, input int r, input int c, input bit cm);
        int n = r * c;
        int k = 0;
        exp_t e;
        if (cm) begin
            for (int j = 0; j < c; j++)
                for (int i = 0; i < r; i++) begin
                    e.data = 32'((base + i * c + j) % (1 << AW));
                    e.last = (k == n - 1);
                    exp_q.push_back(e);
                    k++;
                end
        end else begin
            for (int m = 0; m < n; m++) begin
                e.data = 32'((base + m) % (1 << AW));
                e.last = (m == n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_walk(input int base, input int r, input int c, input bit cm,
                            input bit poke, output int lat);
        bit seen = 1'b0;
        lat = -1;
        push_walk(base, r, c, cm);
        first_pop = -1;
        pop_cnt = 0;
        cfg_base = AW'(base);
        cfg_rows = DIM_W'(r);
        cfg_cols = DIM_W'(c);
        cfg_col_major = cm;
        zero_start = (r == 0) || (c == 0);
        start = 1'b1;
        @(posedge clka);
        #1;
        start = 1'b0;
        zero_start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clka);
            if (poke && i == 2) begin
                cfg_rows = DIM_W'(5);
                start = 1'b1;
            end
            if (poke && i == 3) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat = i;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("all_popped", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clka);
        #1;
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clka);
        #1;
        rsta = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_shift", 32'(dp_shift), 32'd0);
        check("rst_out_sel", 32'(dp_out_sel), 32'd2);
        check("rst_addra", 32'(dp_addra), 32'd0);
        @(posedge clka);
        #1;

        run_walk(16, 2, 3, 1'b0, 1'b0, lat);
        check("first_valid_lat", 32'(first_pop - start_cyc), 32'd3);
        check("throughput_rm", 32'(last_pop - first_pop), 32'd5);

        run_walk(16, 2, 3, 1'b1, 1'b1, lat);
        check("first_valid_lat_cm", 32'(first_pop - start_cyc), 32'd3);
        check("throughput_cm", 32'(last_pop - first_pop), 32'd5);

        rdy_idx = 0;
        rdy_mode = 1;
        run_walk(0, 4, 4, 1'b0, 1'b0, lat);
        check("stall_count", 32'(pop_cnt), 32'd16);
        rdy_mode = 0;
        @(posedge clka);
        #1;

        run_walk(12'hFFE, 1, 4, 1'b0, 1'b0, lat);
        check("wrap_count", 32'(pop_cnt), 32'd4);

        run_walk(256, 0, 3, 1'b0, 1'b0, lat);
        check("zero_done_lat", 32'(lat), 32'd0);
        check("zero_pops", 32'(pop_cnt), 32'd0);
        repeat (4) begin
            @(negedge clka);
            check("zero_valid", 32'(m_valid), 32'd0);
            check("zero_shift", 32'(dp_shift), 32'd0);
            check("zero_busy", 32'(busy), 32'd0);
        end
        @(posedge clka);
        #1;

        cfg_base = AW'(64);
        cfg_rows = DIM_W'(4);
        cfg_cols = DIM_W'(4);
        cfg_col_major = 1'b0;
        start = 1'b1;
        @(posedge clka);
        #1;
        start = 1'b0;
        @(posedge clka);
        #1;
        rsta = 1'b1;
        @(posedge clka);
        #1;
        rsta = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_shift", 32'(dp_shift), 32'd0);
        repeat (4) begin
            @(negedge clka);
            check("abort_idle_valid", 32'(m_valid), 32'd0);
        end
        @(posedge clka);
        #1;
        run_walk(512, 3, 3, 1'b1, 1'b0, lat);
        check("post_abort_count", 32'(pop_cnt), 32'd9);
        check("post_abort_lat", 32'(first_pop - start_cyc), 32'd3);

        rdy_idx = 6;
        rdy_mode = 1;
        for (int t = 0; t < 6; t++) begin
            int r = int'($urandom_range(1, 5));
            int c = int'($urandom_range(1, 5));
            run_walk(int'($urandom_range(0, (1 << AW) - 1)), r, c,
                     1'($urandom_range(0, 1)), 1'b0, lat);
            check("rand_count", 32'(pop_cnt), 32'(r * c));
        end
        rdy_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_rd_seq.md
Name: matrix_rd_seq

Overview:
- Read sequencer directly upstream of matrix_dp; sole driver of its read-side controls (addra, shift, out_sel) while busy.
- Walks an R x C matrix stored row-major at a base address, in row-major or column-major (transpose) order.
- Issues one RAM read per cycle, tracks the 2-cycle BRAM latency, and manages matrix_dp's two-entry read buffer.
- Presents the element stream (matrix_dp douta) as a valid/ready stream with a last flag to the MAC datapath.

Parameters:
- ADDR_MSB, 11, MSB of RAM word address; must match matrix_dp.
- DIM_W, 7, width of the row/column count fields.

Ports:
- clka  in  1  clock
- rsta  in  1  reset, synchronous, active-high
- start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_base  in  ADDR_MSB+1  address of element [0][0]
- cfg_rows  in  DIM_W  row count R
- cfg_cols  in  DIM_W  column count C
- cfg_col_major  in  1  0 = row-major walk, 1 = column-major walk
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final element is popped
- dp_addra  out  ADDR_MSB+1  to matrix_dp addra
- dp_shift  out  1  to matrix_dp shift
- dp_out_sel  out  2  to matrix_dp out_sel
- dp_douta  in  32  from matrix_dp douta
- m_valid  out  1  stream element valid
- m_ready  in  1  stream consumer ready
- m_data  out  32  equals dp_douta (combinational)
- m_last  out  1  qualifies the final element of the walk

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_last=0, dp_shift=0, dp_out_sel=2'b10, dp_addra=0. Reset also clears FSM state, counters, in-flight flags and buffer valid bits; reset mid-walk discards all in-flight data, and no done is produced for the aborted walk.
- FSM IDLE -> RUN -> DRAIN -> IDLE:
  - IDLE: start latches cfg_* and loads remaining = R*C. If R=0 or C=0, done pulses next cycle with no reads and the FSM stays IDLE. Otherwise the FSM enters RUN next cycle. start is ignored when not in IDLE.
  - RUN: issues reads. Moves to DRAIN on the cycle the last address issues.
  - DRAIN: waits for outstanding=0, then pulses done and returns to IDLE.
- Address walk (wraps mod 2^(ADDR_MSB+1)):
  - Row-major: addr increments by 1.
  - Column-major: addr increments by C. At row R-1, line_ptr increments by 1 and addr = line_ptr.
- Issue rule: issue = RUN and (outstanding + 1 - pop) <= 2, where pop = m_valid and m_ready. outstanding = issued but not yet popped, range 0..2. Combinational m_ready -> issue path is permitted.
- Latency: an address issued in cycle t appears on matrix_dp's RAM output in cycle t+2. Two-stage flag pipe iss_d1/iss_d2; arr = iss_d2. First m_valid occurs 3 cycles after start.
- Buffer valid bits v0 (read_buf[0], older) and v1 (read_buf[1]). Legal states are {v0,v1} in {00, 01, 11}; any other state is a bug (assertion).
- Head select:
  - v0: out_sel=00
  - else v1: out_sel=01
  - else arr: out_sel=10
- m_valid = v0 | v1 | arr.
- dp_shift = arr and not (head is RAM and pop). Shift is never asserted without an arrival.
- Valid-bit update:
  - shift: v0' = v1 and not (pop from buf1); v1' = 1.
  - no shift: v0' = v0 and not pop; v1' = v1 and not (pop and head is buf1).
- Buffer overflow is impossible: an arrival with {v0,v1}=11 violates the outstanding limit (assertion).
- remaining decrements on each pop. m_last = m_valid and remaining==1.
- Full throughput with m_ready held high is 1 element per cycle. Any m_ready pattern loses and duplicates no element.

Decomposition:
- Package matrix_pkg holds:
  - enum dp_sel_e {SEL_BUF0=2'b00, SEL_BUF1=2'b01, SEL_RAM=2'b10}, which replaces raw out_sel codes;
  - enum rd_state_e {IDLE, RUN, DRAIN};
  - constant RAM_RD_LAT=2.
- One sub-module, matrix_addr_walk: walk counters, line_ptr, last-issue detect. The FSM, credit and buffer logic stay in the top.

Test Plan:
- Preload RAM with addr value; R=2, C=3, base=0x010, row-major, m_ready=1 -> m_data 0x10..0x15 on consecutive cycles; m_last on 0x15; done 1 cycle after that pop.
- Same matrix, col_major=1 -> order 0x10, 0x13, 0x11, 0x14, 0x12, 0x15.
- Row-major 4x4 with m_ready toggling 1,0,0,1,0,1... and random stalls -> all 16 elements in order, none dropped or duplicated; {v0,v1} never 10; outstanding <= 2.
- base=0xFFE, R=1, C=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001.
- start with R=0 -> done next cycle; no dp_shift; m_valid stays 0.
- rsta asserted mid-walk with 2 reads in flight -> next cycle busy=0, m_valid=0; a new start then yields a clean full walk.
